calc_display: RTL and testbench
===============================

CALC_DISPLAY -- requirements
Module: calc_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clock cycles each digit stays enabled; legal range 1..255.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port res_in, input, 7, unsigned calculator result (0..127).
REQ-005 SHALL have port res_valid, input, 1, result-present strobe, held by producer until accepted.
REQ-006 SHALL have port res_ready, output, 1, high when block can accept a result.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port seg, output, 7, active-high segments; seg[0]=a .. seg[6]=g.
REQ-009 SHALL have port an, output, 3, one-hot active-high digit enable; an[0]=ones, an[1]=tens, an[2]=hundreds.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-011 SHALL drive res_ready=1 only in IDLE; busy=1 in SHIFT and DONE.
REQ-012 SHALL accept on a rising edge with res_valid&&res_ready: latch res_in, clear 12-bit BCD accumulator, zero shift counter, go to SHIFT.
REQ-013 SHALL perform sequential double-dabble in SHIFT: per cycle, add 3 to each BCD nibble >=5, then shift left one bit taking the next res_in MSB.
REQ-014 SHALL execute exactly 7 SHIFT cycles; on the 7th edge go to DONE.
REQ-015 SHALL in DONE copy hundreds/tens/ones into display registers and return to IDLE.
REQ-016 SHALL update the display registers exactly 8 edges after the accept edge; the old value stays displayed until then.
REQ-017 SHALL ignore res_valid while not in IDLE; no queuing, no loss of the in-flight conversion.
REQ-018 SHALL support back-to-back results: next accept possible on the edge leaving DONE+1, giving 9-cycle throughput.
REQ-019 SHALL run a free-running prescaler 0..SCAN_DIV-1; on wrap, digit index advances 0->1->2->0.
REQ-020 SHALL drive an one-hot from the digit index and seg as the 7-seg decode of the selected display register, combinationally.
REQ-021 SHALL decode digits 0-9 to standard patterns; unreachable codes 10-15 decode to seg=0.
REQ-022 SHALL keep scanning independent of conversion activity; the FSM never stalls the scan.

Reset
REQ-023 SHALL on reset assertion immediately force: state IDLE, res_ready=1, busy=0, display registers 0, prescaler 0, digit index 0, an=3'b001, seg=7'b0111111.
REQ-024 SHALL abort a conversion in progress on reset; the partial result is never displayed.

Configuration
REQ-025 SHALL, with CALC_DISP_LEADING_ZERO_BLANK_EN defined, force seg=0 for hundreds when it is 0, and for tens when hundreds and tens are both 0; ones is never blanked; an still scans.
REQ-026 SHALL, without CALC_DISP_LEADING_ZERO_BLANK_EN, display all three digits unconditionally; the reset seg value in REQ-023 holds in both builds.

Structure
REQ-027 SHALL place the FSM state enum, 4-bit BCD digit type, and the ten segment-pattern constants in shared package calc_pkg.
REQ-028 SHALL instantiate one sub-module, seg7_decode (4-bit digit in, 7-bit seg out, purely combinational); everything else stays in calc_display.

Verification
REQ-029 SHALL cover: res_in=127 accepted -> after 8 edges display registers hold 1,2,7; an sequence 001,010,100 with SCAN_DIV-cycle dwell; seg 0000110, 1011011, 0000111.
REQ-030 SHALL cover: res_in=0 -> display 0,0,0; blanking build: an[2], an[1] slots seg=0, an[0] slot seg=0111111.
REQ-031 SHALL cover: res_in=100 -> display 1,0,0; blanking build shows all three digits (tens zero not blanked).
REQ-032 SHALL cover: res_in=5 accepted, then res_valid held with res_in=9 during SHIFT -> 5 displayed first, 9 accepted only once res_ready returns, then displayed.
REQ-033 SHALL cover: reset asserted at SHIFT cycle 4 of res_in=88 -> asynchronous return to REQ-023 values, display stays 0,0,0 after release.
REQ-034 SHALL cover: SCAN_DIV=1 -> an changes every cycle, continuous 001,010,100 rotation during a conversion.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result display: FSM states,
// BCD digit type and the active-high 7-segment patterns (seg[0]=a .. seg[6]=g).
package calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment decoder; codes 10-15 light nothing.
module seg7_decode
    import calc_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b0000000;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/calc_display.sv
// Converts a 7-bit result to BCD by sequential double-dabble and scans it onto a
// 3-digit multiplexed 7-segment display. CALC_DISP_LEADING_ZERO_BLANK_EN blanks leading zeros.
module calc_display
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] res_in,
    input  logic       res_valid,
    output logic       res_ready,
    output logic       busy,
    output logic [6:0] seg,
    output logic [2:0] an
);

    localparam logic [7:0] PRE_MAX = 8'(SCAN_DIV - 1);

    state_e      state_q, state_d;
    logic [6:0]  sh_q, sh_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    bcd_t        disp_h_q, disp_h_d;
    bcd_t        disp_t_q, disp_t_d;
    bcd_t        disp_o_q, disp_o_d;
    logic [7:0]  pre_q, pre_d;
    logic [1:0]  dig_q, dig_d;

    bcd_t        sel_digit;
    logic [6:0]  dec_seg;
    logic        blank;

    // One double-dabble step: correct every nibble >= 5, then shift in the next bit.
    function automatic logic [11:0] dabble_step(input logic [11:0] acc, input logic bit_in);
        logic [11:0] a;
        a = acc;
        for (int n = 0; n < 3; n++) begin
            if (a[n*4 +: 4] >= 4'd5) begin
                a[n*4 +: 4] = a[n*4 +: 4] + 4'd3;
            end
        end
        return (a << 1) | {11'b0, bit_in};
    endfunction

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        disp_h_d  = disp_h_q;
        disp_t_d  = disp_t_q;
        disp_o_d  = disp_o_q;
        res_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    sh_d    = res_in;
                    bcd_d   = 12'd0;
                    cnt_d   = 3'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy  = 1'b1;
                bcd_d = dabble_step(bcd_q, sh_q[6]);
                sh_d  = {sh_q[5:0], 1'b0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy     = 1'b1;
                disp_h_d = bcd_q[11:8];
                disp_t_d = bcd_q[7:4];
                disp_o_d = bcd_q[3:0];
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan runs regardless of the converter.
    always_comb begin
        pre_d = pre_q + 8'd1;
        dig_d = dig_q;
        if (pre_q >= PRE_MAX) begin
            pre_d = 8'd0;
            dig_d = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sh_q     <= 7'd0;
            bcd_q    <= 12'd0;
            cnt_q    <= 3'd0;
            disp_h_q <= 4'd0;
            disp_t_q <= 4'd0;
            disp_o_q <= 4'd0;
            pre_q    <= 8'd0;
            dig_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            disp_h_q <= disp_h_d;
            disp_t_q <= disp_t_d;
            disp_o_q <= disp_o_d;
            pre_q    <= pre_d;
            dig_q    <= dig_d;
        end
    end

    always_comb begin
        an        = 3'b001;
        sel_digit = disp_o_q;
        case (dig_q)
            2'd1: begin
                an        = 3'b010;
                sel_digit = disp_t_q;
            end
            2'd2: begin
                an        = 3'b100;
                sel_digit = disp_h_q;
            end
            default: begin
                an        = 3'b001;
                sel_digit = disp_o_q;
            end
        endcase
    end

    seg7_decode u_dec (
        .digit (sel_digit),
        .seg   (dec_seg)
    );

    always_comb begin
`ifdef CALC_DISP_LEADING_ZERO_BLANK_EN
        blank = ((dig_q == 2'd2) && (disp_h_q == 4'd0)) ||
                ((dig_q == 2'd1) && (disp_h_q == 4'd0) && (disp_t_q == 4'd0));
`else
        blank = 1'b0;
`endif
        seg = blank ? 7'b0000000 : dec_seg;
    end

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display: one instance at SCAN_DIV=4 and one at SCAN_DIV=1
// share the same stimulus; expectations follow CALC_DISP_LEADING_ZERO_BLANK_EN.
module tb_calc_display;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] res_in = 7'd0;
    logic       res_valid = 1'b0;

    logic       a_ready, a_busy, b_ready, b_busy;
    logic [6:0] a_seg, b_seg;
    logic [2:0] a_an, b_an;

    int total = 0;
    int bad = 0;
    int dh = 0, dt = 0, dol = 0;

`ifdef CALC_DISP_LEADING_ZERO_BLANK_EN
    localparam bit BLK = 1'b1;
`else
    localparam bit BLK = 1'b0;
`endif

    logic [6:0] pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                             7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    calc_display #(.SCAN_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .res_in(res_in), .res_valid(res_valid),
        .res_ready(a_ready), .busy(a_busy), .seg(a_seg), .an(a_an)
    );

    calc_display #(.SCAN_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .res_in(res_in), .res_valid(res_valid),
        .res_ready(b_ready), .busy(b_busy), .seg(b_seg), .an(b_an)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] exp_seg(input logic [2:0] an_v, input int h, input int t, input int o);
        case (an_v)
            3'b001:  return pat[o];
            3'b010:  return (BLK && h == 0 && t == 0) ? 7'b0000000 : pat[t];
            3'b100:  return (BLK && h == 0) ? 7'b0000000 : pat[h];
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [2:0] rotl(input logic [2:0] a);
        return {a[1:0], a[2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Observe every digit slot of the SCAN_DIV=4 instance over one full scan period.
    task automatic cap_a(input string tag, input int h, input int t, input int o);
        logic [6:0] got [3];
        bit         seen [3];
        for (int i = 0; i < 3; i++) begin
            got[i] = 7'd0;
            seen[i] = 1'b0;
        end
        for (int c = 0; c < 12; c++) begin
            tick;
            for (int i = 0; i < 3; i++) begin
                if (a_an == 3'(1 << i)) begin
                    got[i] = a_seg;
                    seen[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_digit", $sformatf("%0d", i)}, seen[i] ? 32'(got[i]) : 32'hDEAD,
                32'(exp_seg(3'(1 << i), h, t, o)));
        end
    endtask

    task automatic cap_b(input string tag, input int h, input int t, input int o);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk({tag, "_fast"}, 32'(b_seg), 32'(exp_seg(b_an, h, t, o)));
        end
    endtask

    task automatic convert(input string tag, input int v);
        logic [2:0] prev;
        res_in = 7'(v);
        res_valid = 1'b1;
        prev = b_an;
        tick;
        res_valid = 1'b0;
        chk({tag, "_ready_lo"}, 32'(a_ready), 32'd0);
        chk({tag, "_busy_hi"}, 32'(a_busy), 32'd1);
        chk({tag, "_rot"}, 32'(b_an), 32'(rotl(prev)));
        prev = b_an;
        for (int i = 1; i <= 7; i++) begin
            tick;
            chk({tag, "_rot"}, 32'(b_an), 32'(rotl(prev)));
            prev = b_an;
        end
        chk({tag, "_busy7"}, 32'(a_busy), 32'd1);
        chk({tag, "_old_disp"}, 32'(b_seg), 32'(exp_seg(b_an, dh, dt, dol)));
        tick;
        dh = v / 100;
        dt = (v / 10) % 10;
        dol = v % 10;
        chk({tag, "_busy8"}, 32'(a_busy), 32'd0);
        chk({tag, "_ready8"}, 32'(a_ready), 32'd1);
        chk({tag, "_new_disp"}, 32'(b_seg), 32'(exp_seg(b_an, dh, dt, dol)));
    endtask

    initial begin
        logic [2:0] prev;
        int run;
        bit changed;

        // Asynchronous reset before any clock edge
        #1 reset = 1'b1;
        #1;
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_an", 32'(a_an), 32'b001);
        chk("rst_seg", 32'(a_seg), 32'b0111111);
        @(negedge clk);
        reset = 1'b0;

        // Scan order and dwell at SCAN_DIV=4
        prev = a_an;
        run = 1;
        changed = 1'b0;
        for (int c = 0; c < 24; c++) begin
            tick;
            if (a_an != prev) begin
                if (changed) chk("dwell", 32'(run), 32'd4);
                chk("scan_order", 32'(a_an), 32'(rotl(prev)));
                changed = 1'b1;
                run = 1;
                prev = a_an;
            end else begin
                run++;
            end
        end
        chk("scan_seen_change", 32'(changed), 32'd1);

        convert("r127", 127);
        cap_a("r127", 1, 2, 7);

        convert("r0", 0);
        cap_a("r0", 0, 0, 0);

        convert("r100", 100);
        cap_a("r100", 1, 0, 0);

        // Result held valid while busy: 5 first, then 9 once ready returns
        res_in = 7'd5;
        res_valid = 1'b1;
        tick;
        res_in = 7'd9;
        chk("hold_ready0", 32'(a_ready), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            tick;
            chk("hold_ready", 32'(a_ready), 32'd0);
        end
        chk("hold_old", 32'(b_seg), 32'(exp_seg(b_an, dh, dt, dol)));
        tick;
        dh = 0; dt = 0; dol = 5;
        chk("hold_ready8", 32'(a_ready), 32'd1);
        chk("hold_five", 32'(b_seg), 32'(exp_seg(b_an, dh, dt, dol)));
        tick;
        res_valid = 1'b0;
        chk("second_accept", 32'(a_busy), 32'd1);
        cap_b("five_kept", 0, 0, 5);
        for (int i = 0; i < 4; i++) tick;
        chk("nine_busy7", 32'(a_busy), 32'd1);
        tick;
        chk("nine_busy8", 32'(a_busy), 32'd0);
        dol = 9;
        cap_a("r9", 0, 0, 9);

        // Reset in the middle of a conversion of 88
        res_in = 7'd88;
        res_valid = 1'b1;
        tick;
        res_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        chk("mid_busy", 32'(a_busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_ready", 32'(a_ready), 32'd1);
        chk("arst_busy", 32'(a_busy), 32'd0);
        chk("arst_an", 32'(a_an), 32'b001);
        chk("arst_seg", 32'(a_seg), 32'b0111111);
        chk("arst_an_fast", 32'(b_an), 32'b001);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick;
        chk("post_rst_busy", 32'(a_busy), 32'd0);
        dh = 0; dt = 0; dol = 0;
        cap_a("post_rst", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
